// File: rtl/can_rx_uplink_arbiter_pkg.sv
// Shared types and default sizes for the CAN RX -> elink uplink arbiter.
package mopshub_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int N_BUS_DEF       = 16;
  localparam int DATA_W_DEF      = 76;
  localparam int SEL_W_DEF       = 5;
  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/can_rx_uplink_arbiter_rr_pick.sv
// Round-robin winner selection: first eligible bus after last_grant, wrapping,
// with last_grant itself considered last.
module rr_pick
  import mopshub_arb_pkg::*;
#(
  parameter int N_BUS = N_BUS_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_BUS-1:0] i_eligible,
  input  logic [SEL_W-1:0] i_last_grant,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any_valid
);

  localparam int IDX_W = (N_BUS > 1) ? $clog2(N_BUS) : 1;

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest eligible bus is written last.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int k = N_BUS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last_grant) + k) % N_BUS);
      if (i_eligible[w_idx]) begin
        o_winner    = SEL_W'(w_idx);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_rx_uplink_arbiter.sv
// Shares the single elink uplink among the CAN RX frame buffers: grants one bus,
// captures its frame, and holds it until the encoder consumes it or a timeout drops it.
//
// state | meaning
// IDLE  | no frame in flight; pick a winner among eligible buses
// GRANT | frame captured, ack/irq pulse visible for this one cycle
// WAIT  | frame held for the encoder; count cycles toward timeout
module can_rx_uplink_arbiter
  import mopshub_arb_pkg::*;
#(
  parameter int N_BUS       = N_BUS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        n_buses,
  input  logic [N_BUS-1:0]        bus_req,
  input  logic [N_BUS*DATA_W-1:0] bus_data,
  output logic [N_BUS-1:0]        bus_ack,
  input  logic                    uplink_done,
  output logic [SEL_W-1:0]        can_rec_select,
  output logic [DATA_W-1:0]       data_rec_uplink,
  output logic                    irq_elink_rec,
  output logic                    arb_busy,
  output logic                    timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_last_grant;
  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_data;
  logic [N_BUS-1:0]   r_ack;
  logic               r_irq;
  logic               r_tout;

  logic [N_BUS-1:0]   w_eligible;
  logic [SEL_W-1:0]   w_winner;
  logic               w_any_valid;

  // Buses above n_buses are masked; values >= N_BUS-1 leave every bus enabled.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < N_BUS; i++) begin
      w_eligible[i] = bus_req[i] && (i <= int'(n_buses));
    end
  end

  rr_pick #(
    .N_BUS (N_BUS),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= SEL_W'(N_BUS - 1);
      r_sel        <= '0;
      r_data       <= '0;
      r_ack        <= '0;
      r_irq        <= 1'b0;
      r_tout       <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_irq  <= 1'b0;
      r_tout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_sel   <= w_winner;
            r_data  <= bus_data[int'(w_winner)*DATA_W +: DATA_W];
            r_ack   <= N_BUS'(1) << w_winner;
            r_irq   <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // last_grant moves only on exit so the next IDLE pick skips this bus.
          if (uplink_done) begin
            r_last_grant <= r_sel;
            r_state      <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_tout       <= 1'b1;
            r_last_grant <= r_sel;
            r_state      <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_ack         = r_ack;
  assign can_rec_select  = r_sel;
  assign data_rec_uplink = r_data;
  assign irq_elink_rec   = r_irq;
  assign timeout_err     = r_tout;
  assign arb_busy        = (r_state == GRANT) || (r_state == WAIT);

endmodule

// File: tb/tb_can_rx_uplink_arbiter.sv
// Self-checking bench for can_rx_uplink_arbiter: directed scenarios plus
// randomized traffic checked against a round-robin reference model.
module tb_can_rx_uplink_arbiter;

  localparam int N_BUS       = 16;
  localparam int DATA_W      = 76;
  localparam int SEL_W       = 5;
  localparam int TIMEOUT_CYC = 1024;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [SEL_W-1:0]        n_buses;
  logic [N_BUS-1:0]        bus_req;
  logic [N_BUS*DATA_W-1:0] bus_data;
  logic [N_BUS-1:0]        bus_ack;
  logic                    uplink_done;
  logic [SEL_W-1:0]        can_rec_select;
  logic [DATA_W-1:0]       data_rec_uplink;
  logic                    irq_elink_rec;
  logic                    arb_busy;
  logic                    timeout_err;

  always #5 clk = ~clk;

  can_rx_uplink_arbiter #(
    .N_BUS       (N_BUS),
    .DATA_W      (DATA_W),
    .SEL_W       (SEL_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .n_buses         (n_buses),
    .bus_req         (bus_req),
    .bus_data        (bus_data),
    .bus_ack         (bus_ack),
    .uplink_done     (uplink_done),
    .can_rec_select  (can_rec_select),
    .data_rec_uplink (data_rec_uplink),
    .irq_elink_rec   (irq_elink_rec),
    .arb_busy        (arb_busy),
    .timeout_err     (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [DATA_W-1:0] m_data [N_BUS];
  int                m_last;
  int                m_sel;
  logic [DATA_W-1:0] m_dat;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_frame();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  task automatic set_req(input int i, input logic [DATA_W-1:0] d);
    bus_req[i] = 1'b1;
    m_data[i]  = d;
    bus_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic model_reset();
    m_last = N_BUS - 1;
    m_sel  = 0;
    m_dat  = '0;
  endtask

  // First eligible bus after the last served one, wrapping; the last one is tried last.
  function automatic int ref_pick();
    int i;
    for (int k = 1; k <= N_BUS; k++) begin
      i = (m_last + k) % N_BUS;
      if (bus_req[i] && i <= int'(n_buses)) return i;
    end
    return -1;
  endfunction

  task automatic idle_check(input int n);
    for (int j = 0; j < n; j++) begin
      step();
      chk("idle_flags", {irq_elink_rec, arb_busy, timeout_err, bus_ack}, '0);
      chk("idle_hold", {can_rec_select, data_rec_uplink}, {SEL_W'(m_sel), m_dat});
    end
  endtask

  // One full transfer: grant, GRANT cycle, WAIT until done (done_after>0) or timeout.
  task automatic do_txn(input int done_after, input bit hold, output int got);
    int exp;
    bit left;
    got = -1;
    exp = ref_pick();
    if (exp < 0) begin
      idle_check(1);
      return;
    end
    step();
    chk("grant_irq", irq_elink_rec, 1'b1);
    chk("grant_sel", can_rec_select, SEL_W'(exp));
    chk("grant_data", data_rec_uplink, m_data[exp]);
    chk("grant_ack", bus_ack, N_BUS'(1) << exp);
    chk("grant_busy", {arb_busy, timeout_err}, 2'b10);
    got   = int'(can_rec_select);
    m_sel = exp;
    m_dat = m_data[exp];
    if (!hold) bus_req[exp] = 1'b0;
    step();
    chk("grant_pulse_clr", {irq_elink_rec, bus_ack, arb_busy}, {1'b0, N_BUS'(0), 1'b1});
    left = 1'b0;
    for (int c = 1; c <= TIMEOUT_CYC + 1 && !left; c++) begin
      if (c == done_after) uplink_done = 1'b1;
      step();
      uplink_done = 1'b0;
      if (c == done_after) begin
        chk("done_exit", {arb_busy, timeout_err}, 2'b00);
        left = 1'b1;
      end else if (c == TIMEOUT_CYC) begin
        chk("timeout_exit", {arb_busy, timeout_err}, 2'b01);
        left = 1'b1;
      end else begin
        chk("wait_flags", {arb_busy, timeout_err, irq_elink_rec, bus_ack}, {3'b100, N_BUS'(0)});
        chk("wait_hold", {can_rec_select, data_rec_uplink}, {SEL_W'(m_sel), m_dat});
      end
    end
    chk("wait_exit", left, 1'b1);
    m_last = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int order [5];
    order = '{0, 4, 15, 0, 4};

    rst         = 1'b0;
    n_buses     = SEL_W'(N_BUS - 1);
    bus_req     = '0;
    bus_data    = '0;
    uplink_done = 1'b0;
    for (int i = 0; i < N_BUS; i++) m_data[i] = '0;
    model_reset();

    // reset
    repeat (3) step();
    chk("reset_outputs", {bus_ack, can_rec_select, data_rec_uplink, irq_elink_rec, arb_busy, timeout_err}, '0);
    rst = 1'b1;
    idle_check(4);

    // single request
    set_req(3, DATA_W'(76'hA5));
    do_txn(5, 1'b0, got);
    chk("single_bus", got, 3);
    idle_check(2);

    // fairness from reset state
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    set_req(0, rand_frame());
    set_req(4, rand_frame());
    set_req(15, rand_frame());
    for (int j = 0; j < 5; j++) begin
      do_txn(2, 1'b1, got);
      chk("fair_order", got, order[j]);
    end
    bus_req = '0;
    idle_check(2);

    // masking
    n_buses = SEL_W'(4);
    set_req(15, rand_frame());
    set_req(2, rand_frame());
    do_txn(3, 1'b0, got);
    chk("mask_bus", got, 2);
    idle_check(5);
    bus_req[15] = 1'b0;
    n_buses = SEL_W'(N_BUS - 1);

    // timeout, then done coinciding with the timeout edge
    set_req(7, rand_frame());
    do_txn(0, 1'b0, got);
    chk("tout_bus", got, 7);
    idle_check(2);
    set_req(7, rand_frame());
    do_txn(TIMEOUT_CYC, 1'b0, got);
    idle_check(2);

    // reset during WAIT of bus 9
    set_req(9, rand_frame());
    step();
    chk("rstw_grant", can_rec_select, SEL_W'(9));
    bus_req[9] = 1'b0;
    repeat (3) step();
    chk("rstw_in_wait", arb_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstw_async", {bus_ack, can_rec_select, data_rec_uplink, irq_elink_rec, arb_busy, timeout_err}, '0);
    step();
    step();
    rst = 1'b1;
    model_reset();
    set_req(12, rand_frame());
    set_req(9, rand_frame());
    do_txn(1, 1'b0, got);
    chk("rstw_regrant", got, 9);
    do_txn(1, 1'b0, got);
    chk("rstw_next", got, 12);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N_BUS; i++) begin
        if (!bus_req[i] && $urandom_range(0, 3) == 0) set_req(i, rand_frame());
      end
      n_buses = SEL_W'($urandom_range(0, 31));
      do_txn($urandom_range(1, 6), 1'b0, got);
    end
    bus_req = '0;
    idle_check(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
